// File: rtl/bf_pkg.sv
// Shared types for the Brainfuck core: opcode and state encodings, error codes.
package bf_pkg;

  typedef enum logic [2:0] {
    OP_INC_SP = 3'd0,
    OP_DEC_SP = 3'd1,
    OP_INC    = 3'd2,
    OP_DEC    = 3'd3,
    OP_OUT    = 3'd4,
    OP_IN     = 3'd5,
    OP_LOOP   = 3'd6,
    OP_END    = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_EXEC     = 3'd0,
    S_SKIP     = 3'd1,
    S_OUT_WAIT = 3'd2,
    S_IN_WAIT  = 3'd3,
    S_HALT     = 3'd4
  } state_e;

  localparam logic [2:0] ERR_NONE            = 3'd0;
  localparam logic [2:0] ERR_STACK_OVERFLOW  = 3'd1;
  localparam logic [2:0] ERR_UNMATCHED_END   = 3'd2;
  localparam logic [2:0] ERR_UNMATCHED_BEGIN = 3'd3;
  localparam logic [2:0] ERR_TAPE_BOUND      = 3'd4;

endpackage

// File: rtl/bf_loop_stack.sv
// Loop-return LIFO: holds the pc of each open '['. Async reset empties it;
// push while full and pop while empty are ignored (the core faults first).
module bf_loop_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     mem_q [DEPTH];

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign top_o   = mem_q[PTR_W'(cnt_q - CNT_W'(1))];

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !full_o)       cnt_d = cnt_q + CNT_W'(1);
    else if (pop_i && !empty_o)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clock) begin
    if (push_i && !full_o) mem_q[PTR_W'(cnt_q)] <= push_data_i;
  end

endmodule

// File: rtl/bf_core_param.sv
// Parametrised Brainfuck execution core with hardware loop resolution and
// valid/ready byte I/O. Define BF_TAPE_BOUND_EN to fault on tape under/overflow.
module bf_core_param
  import bf_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TAPE_AW     = 16,
  parameter int PROG_AW     = 16,
  parameter int PROG_LEN    = 65535,
  parameter int STACK_DEPTH = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [PROG_AW-1:0] pc,
  input  logic [2:0]         pmem_data_read,
  output logic [TAPE_AW-1:0] sp,
  input  logic [DATA_W-1:0]  tape_data_read,
  output logic               tape_we,
  output logic [DATA_W-1:0]  tape_data_write,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               halted,
  output logic [2:0]         err_code
);

  localparam logic [PROG_AW-1:0] PC_END = PROG_AW'(PROG_LEN);

  state_e             state_q, state_d;
  logic [PROG_AW-1:0] pc_q, pc_d, pc_inc;
  logic [TAPE_AW-1:0] sp_q, sp_d;
  logic [PROG_AW-1:0] depth_q, depth_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               halted_q, halted_d;
  logic [2:0]         err_q, err_d;

  logic               we, push, pop;
  logic [DATA_W-1:0]  wdata;
  logic [PROG_AW-1:0] stk_top;
  logic               stk_full, stk_empty;
  opcode_e            op;
  logic               cell_zero;

  assign op        = opcode_e'(pmem_data_read);
  assign cell_zero = (tape_data_read == '0);
  assign pc_inc    = pc_q + PROG_AW'(1);

  bf_loop_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PROG_AW)
  ) u_stack (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_q),
    .top_o       (stk_top),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    depth_d    = depth_q;
    out_data_d = out_data_q;
    halted_d   = halted_q;
    err_d      = err_q;
    we         = 1'b0;
    wdata      = '0;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (pc_q == PC_END) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          err_d    = ERR_NONE;
        end else begin
          case (op)
            OP_INC_SP: begin
`ifdef BF_TAPE_BOUND_EN
              if (sp_q == '1) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
                err_d    = ERR_TAPE_BOUND;
              end else
`endif
              begin
                sp_d = sp_q + TAPE_AW'(1);
                pc_d = pc_inc;
              end
            end
            OP_DEC_SP: begin
`ifdef BF_TAPE_BOUND_EN
              if (sp_q == '0) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
                err_d    = ERR_TAPE_BOUND;
              end else
`endif
              begin
                sp_d = sp_q - TAPE_AW'(1);
                pc_d = pc_inc;
              end
            end
            OP_INC: begin
              we    = 1'b1;
              wdata = tape_data_read + DATA_W'(1);
              pc_d  = pc_inc;
            end
            OP_DEC: begin
              we    = 1'b1;
              wdata = tape_data_read - DATA_W'(1);
              pc_d  = pc_inc;
            end
            OP_OUT: begin
              state_d    = S_OUT_WAIT;
              out_data_d = tape_data_read;
            end
            OP_IN: state_d = S_IN_WAIT;
            OP_LOOP: begin
              if (cell_zero) begin
                depth_d = PROG_AW'(1);
                pc_d    = pc_inc;
                state_d = S_SKIP;
              end else if (stk_full) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
                err_d    = ERR_STACK_OVERFLOW;
              end else begin
                push = 1'b1;
                pc_d = pc_inc;
              end
            end
            OP_END: begin
              if (stk_empty) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
                err_d    = ERR_UNMATCHED_END;
              end else if (!cell_zero) begin
                pc_d = stk_top + PROG_AW'(1);
              end else begin
                pop  = 1'b1;
                pc_d = pc_inc;
              end
            end
            default: ;
          endcase
        end
      end
      S_SKIP: begin
        if (pc_q == PC_END) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          err_d    = ERR_UNMATCHED_BEGIN;
        end else begin
          pc_d = pc_inc;
          if (op == OP_LOOP) begin
            depth_d = depth_q + PROG_AW'(1);
          end else if (op == OP_END) begin
            depth_d = depth_q - PROG_AW'(1);
            if (depth_q == PROG_AW'(1)) state_d = S_EXEC;
          end
        end
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          state_d = S_EXEC;
          pc_d    = pc_inc;
        end
      end
      S_IN_WAIT: begin
        if (in_valid) begin
          we      = 1'b1;
          wdata   = in_data;
          state_d = S_EXEC;
          pc_d    = pc_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_EXEC;
      pc_q       <= '0;
      sp_q       <= '0;
      depth_q    <= '0;
      out_data_q <= '0;
      halted_q   <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      depth_q    <= depth_d;
      out_data_q <= out_data_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  // The write strobe is combinational, so hold it off while reset is asserted.
  assign tape_we         = we & reset_n;
  assign tape_data_write = tape_we ? wdata : '0;
  assign pc              = pc_q;
  assign sp              = sp_q;
  assign out_valid       = (state_q == S_OUT_WAIT);
  assign out_data        = out_data_q;
  assign in_ready        = (state_q == S_IN_WAIT);
  assign halted          = halted_q;
  assign err_code        = err_q;

endmodule
